// File: rtl/aibnd_dcc_cal_ctrl_if.sv
// Control/status bundle between the DCC calibration controller and its
// sense/trim neighbours (or a test driver).
interface aibnd_dcc_cal_ctrl_if #(
    parameter int unsigned CODE_W = 8
);
    logic              dcc_en;
    logic              up;
    logic              dcc_ovr_en;
    logic [CODE_W-1:0] dcc_ovr_code;
    logic [CODE_W-1:0] dcc_code;
    logic              dcc_busy;
    logic              dcc_lock;
    logic              dcc_sat;

    modport master (
        output dcc_en, up, dcc_ovr_en, dcc_ovr_code,
        input  dcc_code, dcc_busy, dcc_lock, dcc_sat
    );

    modport slave (
        input  dcc_en, up, dcc_ovr_en, dcc_ovr_code,
        output dcc_code, dcc_busy, dcc_lock, dcc_sat
    );
endinterface

// File: rtl/aibnd_dcc_cal_ctrl.sv
// DCC calibration controller: majority-filters the synchronized sense decision
// over a window, steps the trim code toward balance and flags lock on dither.
module aibnd_dcc_cal_ctrl #(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned WIN_LOG2   = 3,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic                clk_dcc,
    input  logic                dll_reset_n,
    aibnd_dcc_cal_ctrl_if.slave dcc
);

    localparam int unsigned WIN     = 1 << WIN_LOG2;
    localparam int unsigned CNT_MAX = (SETTLE_CYC > WIN) ? SETTLE_CYC : WIN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned ONES_W  = WIN_LOG2 + 1;
    localparam int unsigned REV_W   = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MIN = {CODE_W{1'b0}};
    localparam logic [ONES_W-1:0] HALF     = ONES_W'(WIN / 2);
    localparam logic [REV_W-1:0]  REV_LOCK = REV_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         up_sync;
    logic               up_s;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ONES_W-1:0]  ones_cnt, ones_nxt;
    logic [REV_W-1:0]   rev_cnt, rev_nxt;
    logic               prev_vld, prev_vld_nxt;
    logic               prev_inc, prev_inc_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic               busy_nxt, lock_nxt, sat_nxt;
    logic               dir_inc, dir_dec, dir_hold, qualify;

    assign up_s = up_sync[1];

    // Window decision decode, meaningful in DECIDE
    always_comb begin
        dir_inc  = (ones_cnt > HALF);
        dir_dec  = (ones_cnt < HALF);
        dir_hold = !dir_inc && !dir_dec;
        qualify  = dir_hold || (prev_vld && (prev_inc != dir_inc));
    end

    // Next-state and next-output logic; override beats enable
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ones_nxt     = ones_cnt;
        rev_nxt      = rev_cnt;
        prev_vld_nxt = prev_vld;
        prev_inc_nxt = prev_inc;
        code_nxt     = dcc.dcc_code;
        lock_nxt     = dcc.dcc_lock;
        sat_nxt      = dcc.dcc_sat;

        if (dcc.dcc_ovr_en) begin
            state_nxt = IDLE;
            code_nxt  = dcc.dcc_ovr_code;
            lock_nxt  = 1'b0;
            sat_nxt   = 1'b0;
            rev_nxt   = '0;
        end else if (!dcc.dcc_en) begin
            state_nxt = IDLE;
            lock_nxt  = 1'b0;
            sat_nxt   = 1'b0;
            rev_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt    = SETTLE;
                    code_nxt     = CODE_MID;
                    cnt_nxt      = '0;
                    ones_nxt     = '0;
                    rev_nxt      = '0;
                    prev_vld_nxt = 1'b0;
                    prev_inc_nxt = 1'b0;
                    lock_nxt     = 1'b0;
                    sat_nxt      = 1'b0;
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state_nxt = SAMPLE;
                        cnt_nxt   = '0;
                        ones_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    ones_nxt = ones_cnt + ONES_W'(up_s);
                    if (cnt == CNT_W'(WIN - 1)) begin
                        state_nxt = DECIDE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    if (dir_inc) begin
                        prev_vld_nxt = 1'b1;
                        prev_inc_nxt = 1'b1;
                        if (dcc.dcc_code == CODE_MAX) sat_nxt  = 1'b1;
                        else                          code_nxt = dcc.dcc_code + CODE_W'(1);
                    end else if (dir_dec) begin
                        prev_vld_nxt = 1'b1;
                        prev_inc_nxt = 1'b0;
                        if (dcc.dcc_code == CODE_MIN) sat_nxt  = 1'b1;
                        else                          code_nxt = dcc.dcc_code - CODE_W'(1);
                    end
                    if (!qualify)                rev_nxt = '0;
                    else if (rev_cnt != REV_LOCK) rev_nxt = rev_cnt + REV_W'(1);
                    if (rev_nxt == REV_LOCK) lock_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_dcc or negedge dll_reset_n) begin
        if (!dll_reset_n) begin
            state        <= IDLE;
            up_sync      <= '0;
            cnt          <= '0;
            ones_cnt     <= '0;
            rev_cnt      <= '0;
            prev_vld     <= 1'b0;
            prev_inc     <= 1'b0;
            dcc.dcc_code <= CODE_MID;
            dcc.dcc_busy <= 1'b0;
            dcc.dcc_lock <= 1'b0;
            dcc.dcc_sat  <= 1'b0;
        end else begin
            state        <= state_nxt;
            up_sync      <= {up_sync[0], dcc.up};
            cnt          <= cnt_nxt;
            ones_cnt     <= ones_nxt;
            rev_cnt      <= rev_nxt;
            prev_vld     <= prev_vld_nxt;
            prev_inc     <= prev_inc_nxt;
            dcc.dcc_code <= code_nxt;
            dcc.dcc_busy <= busy_nxt;
            dcc.dcc_lock <= lock_nxt;
            dcc.dcc_sat  <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_aibnd_dcc_cal_ctrl.sv
// Directed bench for the DCC calibration controller at default parameters.
module tb_aibnd_dcc_cal_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   up_mode;   // 0: hold up, 1: sense model up=(code<0x90), 2: toggle every cycle

    aibnd_dcc_cal_ctrl_if #(.CODE_W(8)) dcc ();

    aibnd_dcc_cal_ctrl #(
        .CODE_W(8), .SETTLE_CYC(16), .WIN_LOG2(3), .LOCK_CNT(4)
    ) dut (
        .clk_dcc    (clk),
        .dll_reset_n(rst_n),
        .dcc        (dcc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; outputs are sampled and up driven on the falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            case (up_mode)
                1:       dcc.up = (dcc.dcc_code < 8'h90);
                2:       dcc.up = ~dcc.up;
                default: ;
            endcase
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        up_mode          = 0;
        rst_n            = 1'b0;
        dcc.dcc_en       = 1'b0;
        dcc.up           = 1'b0;
        dcc.dcc_ovr_en   = 1'b0;
        dcc.dcc_ovr_code = 8'h00;
        tick(3);
        check("rst_code", 32'(dcc.dcc_code), 32'h80);
        check("rst_busy", 32'(dcc.dcc_busy), 0);
        check("rst_lock", 32'(dcc.dcc_lock), 0);
        check("rst_sat",  32'(dcc.dcc_sat),  0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", 32'(dcc.dcc_busy), 0);

        // Rail saturation with up stuck high
        dcc.up     = 1'b1;
        dcc.dcc_en = 1'b1;
        tick(1);
        check("sat_busy_rise", 32'(dcc.dcc_busy), 1);
        check("sat_code_start", 32'(dcc.dcc_code), 32'h80);
        tick(24);
        check("sat_code_pre1", 32'(dcc.dcc_code), 32'h80);
        tick(1);
        check("sat_code_d1", 32'(dcc.dcc_code), 32'h81);
        for (int d = 2; d <= 127; d++) begin
            tick(25);
            check("sat_code_step", 32'(dcc.dcc_code), 32'(8'h80 + d));
        end
        check("sat_pre_rail", 32'(dcc.dcc_sat), 0);
        tick(25);
        check("sat_code_rail", 32'(dcc.dcc_code), 32'hFF);
        check("sat_flag", 32'(dcc.dcc_sat), 1);
        check("sat_no_lock", 32'(dcc.dcc_lock), 0);
        dcc.dcc_en = 1'b0;
        tick(1);
        check("dis_busy", 32'(dcc.dcc_busy), 0);
        check("dis_sat_clr", 32'(dcc.dcc_sat), 0);
        check("dis_code_hold", 32'(dcc.dcc_code), 32'hFF);

        // Convergence against the sense model
        up_mode    = 1;
        dcc.dcc_en = 1'b1;
        tick(1);
        check("conv_code_start", 32'(dcc.dcc_code), 32'h80);
        for (int d = 1; d <= 22; d++) begin
            tick(25);
            if (d == 16) check("conv_code_d16", 32'(dcc.dcc_code), 32'h90);
            if (d == 17) check("conv_code_d17", 32'(dcc.dcc_code), 32'h8F);
            if (d == 19) check("conv_lock_d19", 32'(dcc.dcc_lock), 0);
            if (d == 20) begin
                check("conv_lock_d20", 32'(dcc.dcc_lock), 1);
                check("conv_code_d20", 32'(dcc.dcc_code), 32'h90);
            end
            if (d == 21) begin
                check("conv_code_d21", 32'(dcc.dcc_code), 32'h8F);
                check("conv_lock_d21", 32'(dcc.dcc_lock), 1);
            end
        end
        check("conv_code_d22", 32'(dcc.dcc_code), 32'h90);
        check("conv_lock_d22", 32'(dcc.dcc_lock), 1);

        // Enable drop mid-SAMPLE after lock
        tick(19);
        dcc.dcc_en = 1'b0;
        tick(1);
        check("drop_busy", 32'(dcc.dcc_busy), 0);
        check("drop_lock", 32'(dcc.dcc_lock), 0);
        check("drop_code", 32'(dcc.dcc_code), 32'h90);
        tick(5);
        check("drop_code_hold", 32'(dcc.dcc_code), 32'h90);

        // Re-enable with a balanced 4-of-8 input: all HOLD, lock at 4th decision
        up_mode    = 2;
        dcc.dcc_en = 1'b1;
        tick(1);
        check("bal_busy", 32'(dcc.dcc_busy), 1);
        check("bal_code_start", 32'(dcc.dcc_code), 32'h80);
        check("bal_lock_start", 32'(dcc.dcc_lock), 0);
        tick(75);
        check("bal_lock_d3", 32'(dcc.dcc_lock), 0);
        check("bal_code_d3", 32'(dcc.dcc_code), 32'h80);
        tick(25);
        check("bal_lock_d4", 32'(dcc.dcc_lock), 1);
        check("bal_code_d4", 32'(dcc.dcc_code), 32'h80);

        // Override mid-calibration, taking priority over dcc_en
        tick(30);
        up_mode          = 0;
        dcc.up           = 1'b1;
        dcc.dcc_ovr_en   = 1'b1;
        dcc.dcc_ovr_code = 8'h3C;
        tick(1);
        check("ovr_code", 32'(dcc.dcc_code), 32'h3C);
        check("ovr_busy", 32'(dcc.dcc_busy), 0);
        check("ovr_lock", 32'(dcc.dcc_lock), 0);
        dcc.dcc_ovr_code = 8'h55;
        tick(1);
        check("ovr_code_track", 32'(dcc.dcc_code), 32'h55);
        dcc.dcc_ovr_en = 1'b0;
        tick(1);
        check("ovr_rel_code", 32'(dcc.dcc_code), 32'h80);
        check("ovr_rel_busy", 32'(dcc.dcc_busy), 1);
        tick(75);
        check("ovr_restart_code", 32'(dcc.dcc_code), 32'h83);
        check("ovr_restart_lock", 32'(dcc.dcc_lock), 0);

        // Asynchronous reset mid-SAMPLE, then idle with enable low
        tick(20);
        rst_n = 1'b0;
        #1;
        check("arst_code", 32'(dcc.dcc_code), 32'h80);
        check("arst_busy", 32'(dcc.dcc_busy), 0);
        check("arst_lock", 32'(dcc.dcc_lock), 0);
        check("arst_sat",  32'(dcc.dcc_sat),  0);
        dcc.dcc_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("idle_code_hold", 32'(dcc.dcc_code), 32'h80);
        end
        check("idle_busy_end", 32'(dcc.dcc_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aibnd_dcc_cal_ctrl.md
# aibnd_dcc_cal_ctrl

Duty-cycle-correction calibration controller for the AIB DCC loop. It consumes the `up` decision from the DCC sense block, which compares the clock's high phase against a half-period delay line. It majority-filters that decision over a sample window and steps a DCC trim code toward balance. It declares lock once the loop dithers around the balance point. The block sits beside the DCC sense and DCC trim delay cells and sequences them after DLL reset.

## Interface
Parameters:
- CODE_W, 8: trim code width; reset/restart code is midscale 2^(CODE_W-1).
- SETTLE_CYC, 16: cycles waited after each code update before sampling (≥ 3, covers the 2-flop sync).
- WIN_LOG2, 3: sample window is 2^WIN_LOG2 cycles.
- LOCK_CNT, 4: qualifying decisions required for lock.

Ports:
- clk_dcc  in  1  controller clock; one clock domain.
- dll_reset_n  in  1  asynchronous, active-low reset.
- dcc_en  in  1  calibration enable, level sensitive.
- up  in  1  sense decision, asynchronous to clk_dcc; 1 = high phase short, increase the code.
- dcc_ovr_en  in  1  manual override enable.
- dcc_ovr_code  in  CODE_W  override code.
- dcc_code  out  CODE_W  trim code to the DCC delay cell (registered).
- dcc_busy  out  1  high in any state except IDLE.
- dcc_lock  out  1  lock indication, sticky while dcc_en is high.
- dcc_sat  out  1  code hit a rail while pushing past it; sticky while dcc_en is high.

## Operation
- `up` passes through a 2-flop synchronizer (up_s) before any use.
- FSM states: IDLE, SETTLE, SAMPLE, DECIDE.
- IDLE: on dcc_en=1 and dcc_ovr_en=0, load code=midscale, clear the counters, lock, sat and prev_dir, then go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: over 2^WIN_LOG2 cycles, ones_cnt accumulates up_s. ones_cnt is WIN_LOG2+1 bits wide and cannot overflow. Then go to DECIDE.
- DECIDE (1 cycle): half = 2^(WIN_LOG2-1).
  - ones_cnt > half gives dir=INC; ones_cnt < half gives dir=DEC; equality gives HOLD.
  - INC at all-ones, or DEC at zero: code unchanged and dcc_sat=1. dir is still recorded as INC/DEC.
  - Otherwise the code moves ±1. No wrap-around, ever.
  - Qualifying decision: HOLD, or dir ≠ prev_dir with prev_dir valid. A qualifying decision increments rev_cnt, which saturates at LOCK_CNT. A non-qualifying decision clears rev_cnt.
  - prev_dir is updated only for INC/DEC.
  - When rev_cnt reaches LOCK_CNT, dcc_lock=1.
  - Then go to SETTLE. Tracking continues after lock; lock never deasserts while dcc_en=1.
- dcc_en=0 in any state: IDLE on the next cycle; lock, sat and rev_cnt clear; dcc_code holds its last value.
- dcc_ovr_en=1 in any state:
  - FSM forced to IDLE on the next cycle; lock and sat clear.
  - dcc_code = dcc_ovr_code, registered with 1 cycle of latency.
  - On release with dcc_en=1, a fresh calibration starts from midscale.
- dcc_ovr_en has priority over dcc_en.

## Timing
- Reset values: dcc_code=midscale (0x80 at defaults), dcc_busy=0, dcc_lock=0, dcc_sat=0, FSM=IDLE, up_s=0.
- dcc_en rise to busy=1: 1 cycle.
- One iteration is SETTLE_CYC + 2^WIN_LOG2 + 1 cycles (25 at defaults).
- dcc_code, dcc_lock and dcc_sat update on the clock edge ending DECIDE.
- The first decision's code is visible 25 cycles after the busy rise.
- An asynchronous reset mid-operation immediately returns every output to its reset value.
- An up transition reaches up_s in 2 cycles. SETTLE_CYC ≥ 3 guarantees that samples reflect the new code.

## Test plan
- Reset/idle: assert dll_reset_n=0 mid-SAMPLE, then release with dcc_en=0 -> dcc_code=0x80, busy/lock/sat=0, and the code holds for 100 cycles.
- Rail saturation: set dcc_en=1, up=1 constant -> code increments by 1 every 25 cycles and reaches 0xFF after 127 decisions. The next decision sets sat=1 with the code held at 0xFF. lock stays 0.
- Convergence: use a sense model with up=(dcc_code<0x90) -> 16 INCs to 0x90, then a 0x8F/0x90 dither. lock=1 at the 20th decision (500 cycles after busy rise) and stays high while the code keeps dithering.
- Balanced input: feed up with exactly 4 ones per 8-cycle window -> every decision is HOLD and the code stays 0x80. lock rises at the 4th decision.
- Override: with dcc_ovr_en=1 and dcc_ovr_code=0x3C mid-calibration -> dcc_code=0x3C one cycle later, busy=0, lock=0. On release with dcc_en=1, the code reloads to 0x80 and calibration restarts.
- Enable drop: deassert dcc_en in SAMPLE after lock at code 0x90 -> IDLE next cycle, lock=0, code holds 0x90. On re-enable the code is 0x80 and lock needs 4 new qualifying decisions.
